sal_bk_ctrl_pp: RTL
===================

// Module: sal_bk_ctrl_pp
// PURPOSE
//  Per-bank DDR2 controller with a selectable page policy (open / closed / adaptive idle-timeout).
//  Sits between the address decoder (one request stream per bank) and the command scheduler.
//  Tracks bank state and per-bank timing (tRCD/tRP/tRAS/tRFC/tRTP/tWTP).
//  Raises ACT/RD/WR/PRE/REF requests to the scheduler.
//  Unlike the previous generation, it precharges an open bank to service refresh.
// PARAMETERS
//  RA_WIDTH     14  row address width
//  CA_WIDTH     10  column address width
//  TCNT_WIDTH   6   width of every timing counter and timing input
//  IDLE_WIDTH   8   width of the adaptive-policy idle counter
// PORTS
//  clk           in   1           clock
//  rst_n         in   1           async active-low reset
//  page_policy_i in   2           0=open, 1=closed, 2=adaptive, 3=reserved (treated as open); sampled every cycle
//  idle_limit_i  in   IDLE_WIDTH  adaptive policy: idle cycles before auto-precharge
//  t_rcd_i/t_rp_i/t_ras_i/t_rfc_i/t_rtp_i/t_wtp_i  in  TCNT_WIDTH each  timing values
//  req_valid_i   in   1           decoder request valid
//  req_wr_i      in   1           1=write, 0=read
//  req_ra_i      in   RA_WIDTH    request row
//  req_ca_i      in   CA_WIDTH    request column
//  req_ready_o   out  1           request consumed this cycle
//  act_req_o/rd_req_o/wr_req_o/pre_req_o/ref_req_o  out  1 each  scheduler requests
//  act_gnt_i/rd_gnt_i/wr_gnt_i/pre_gnt_i/ref_gnt_i  in   1 each  scheduler grants
//  sched_ra_o    out  RA_WIDTH    row for ACT (= req_ra_i)
//  sched_ca_o    out  CA_WIDTH    column for RD/WR (= req_ca_i)
//  ref_req_i     in   1           per-bank refresh request (level, held until granted)
//  ref_gnt_o     out  1           refresh issued this cycle
//  bank_open_o   out  1           state==OPEN
//  open_ra_o     out  RA_WIDTH    currently open row (valid when bank_open_o)
// BEHAVIOUR
//  Reset:
//   - state=CLOSED, open_ra=0, all timing counters=0 (met), idle counter=0, all outputs 0.
//   - Reset mid-operation abandons any pending request with no further commands.
//  Timing counters:
//   - Loaded with t_x on the grant cycle, decrement to 0 and saturate.
//   - "met" is counter==0, so the next command is allowed t_x cycles after the grant edge.
//   - tRCD/tRAS load on ACT, tRP on PRE, tRFC on REF, tRTP on RD, tWTP on WR.
//  Handshake:
//   - All *_req_o are combinational and 0 unless their conditions hold.
//   - A grant counts only in a cycle where its req is high; a grant without req is ignored.
//   - At most one req is high per cycle.
//   - req_ready_o = (rd_gnt_i & rd_req_o) | (wr_gnt_i & wr_req_o), zero-cycle latency.
//  FSM, state CLOSED (requires tRP & tRFC met):
//   - ref_req_i -> ref_req_o; on grant pulse ref_gnt_o.
//   - else req_valid_i -> act_req_o; on grant open_ra<=req_ra_i and go to OPEN.
//   - Refresh has priority over a simultaneous request.
//  FSM, state OPEN:
//   - Pending refresh (ref_req_i): no RD/WR issued; pre_req_o when tRAS & tRTP & tWTP met.
//   - Hit (valid & ra==open_ra): rd/wr_req_o when tRCD met.
//   - Miss: pre_req_o when tRAS & tRTP & tWTP met.
//   - Closed policy: pre_req_o when !req_valid_i and the precharge timers are met.
//   - Adaptive policy: idle counter increments while !req_valid_i, saturates, and clears on
//     any request or grant; pre_req_o when idle>=idle_limit_i and the timers are met.
//     idle_limit_i=0 behaves as closed.
//   - Open policy: precharge only on miss or refresh.
//   - On PRE grant go to CLOSED.
//  Widths: counter compares are unsigned; no wrap (saturating).
//  Policy change mid-operation takes effect on the next cycle and is never unsafe.
// STRUCTURE
//  sal_ddr_pkg:
//   - page_policy_t enum (PP_OPEN, PP_CLOSED, PP_ADAPTIVE).
//   - bank_state_t (BK_CLOSED, BK_OPEN).
//   - Default width constants.
//  Sub-module sal_tcntr (load/decrement/saturate, is_zero_o), instantiated six times.
//  Idle counter and FSM are inline.
// TESTING
//  1. Open policy, tRCD=3, RD row 5 col 9: ACT granted at c0 -> rd_req_o first high at c3;
//     sched_ca_o=9, req_ready_o with grant.
//  2. Open, row 5 open, tRAS=8 and tRP=4, WR to row 7 at c2 after ACT:
//     pre_req_o first at c8; after PRE grant at c8, act_req_o at c12.
//  3. Open bank with tRTP=2, ref_req_i after a RD grant: no further RD, pre_req_o 2 cycles later;
//     after tRP, ref_req_o, ref_gnt_o with grant; ACT blocked for tRFC=20 cycles.
//  4. Closed policy, single RD then valid=0: pre_req_o as soon as tRAS/tRTP are met.
//     Adaptive with idle_limit_i=10: PRE no earlier than 10 idle cycles.
//  5. ref_req_i and req_valid_i together in CLOSED: ref_req_o only, act_req_o=0.
//  6. rst_n low while OPEN with counters running: all outputs 0 immediately, bank_open_o=0;
//     after release, ACT is allowed on the first cycle.

Source files
------------

// File: rtl/sal_ddr_pkg.sv
// Shared DDR2 bank-controller types and defaults.
// Page policy decode and bank state encoding.
package sal_ddr_pkg;

  localparam int DEF_RA_WIDTH   = 14;
  localparam int DEF_CA_WIDTH   = 10;
  localparam int DEF_TCNT_WIDTH = 6;
  localparam int DEF_IDLE_WIDTH = 8;

  typedef enum logic [1:0] {
    PP_OPEN     = 2'd0,
    PP_CLOSED   = 2'd1,
    PP_ADAPTIVE = 2'd2
  } page_policy_t;

  typedef enum logic {
    BK_CLOSED = 1'b0,
    BK_OPEN   = 1'b1
  } bank_state_t;

  // Encoding 3 is reserved and falls back to open page.
  function automatic page_policy_t decode_policy(
    input logic [1:0] raw
  );
    page_policy_t p;
    case (raw)
      2'd1:    p = PP_CLOSED;
      2'd2:    p = PP_ADAPTIVE;
      default: p = PP_OPEN;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sal_bk_ctrl_pp_if.sv
// Bank controller bus: decoder request stream,
// scheduler handshake, timing and policy config.
interface sal_bk_ctrl_pp_if
  import sal_ddr_pkg::*;
#(
  parameter int RA_WIDTH   = DEF_RA_WIDTH,
  parameter int CA_WIDTH   = DEF_CA_WIDTH,
  parameter int TCNT_WIDTH = DEF_TCNT_WIDTH,
  parameter int IDLE_WIDTH = DEF_IDLE_WIDTH
);

  logic [1:0]            page_policy_i;
  logic [IDLE_WIDTH-1:0] idle_limit_i;
  logic [TCNT_WIDTH-1:0] t_rcd_i;
  logic [TCNT_WIDTH-1:0] t_rp_i;
  logic [TCNT_WIDTH-1:0] t_ras_i;
  logic [TCNT_WIDTH-1:0] t_rfc_i;
  logic [TCNT_WIDTH-1:0] t_rtp_i;
  logic [TCNT_WIDTH-1:0] t_wtp_i;

  logic                  req_valid_i;
  logic                  req_wr_i;
  logic [RA_WIDTH-1:0]   req_ra_i;
  logic [CA_WIDTH-1:0]   req_ca_i;
  logic                  req_ready_o;

  logic act_req_o, rd_req_o, wr_req_o;
  logic pre_req_o, ref_req_o;
  logic act_gnt_i, rd_gnt_i, wr_gnt_i;
  logic pre_gnt_i, ref_gnt_i;

  logic [RA_WIDTH-1:0]   sched_ra_o;
  logic [CA_WIDTH-1:0]   sched_ca_o;

  logic                  ref_req_i;
  logic                  ref_gnt_o;
  logic                  bank_open_o;
  logic [RA_WIDTH-1:0]   open_ra_o;

  modport master (
    output page_policy_i, idle_limit_i,
    output t_rcd_i, t_rp_i, t_ras_i,
    output t_rfc_i, t_rtp_i, t_wtp_i,
    output req_valid_i, req_wr_i,
    output req_ra_i, req_ca_i,
    input  req_ready_o,
    input  act_req_o, rd_req_o, wr_req_o,
    input  pre_req_o, ref_req_o,
    output act_gnt_i, rd_gnt_i, wr_gnt_i,
    output pre_gnt_i, ref_gnt_i,
    input  sched_ra_o, sched_ca_o,
    output ref_req_i,
    input  ref_gnt_o, bank_open_o, open_ra_o
  );

  modport slave (
    input  page_policy_i, idle_limit_i,
    input  t_rcd_i, t_rp_i, t_ras_i,
    input  t_rfc_i, t_rtp_i, t_wtp_i,
    input  req_valid_i, req_wr_i,
    input  req_ra_i, req_ca_i,
    output req_ready_o,
    output act_req_o, rd_req_o, wr_req_o,
    output pre_req_o, ref_req_o,
    input  act_gnt_i, rd_gnt_i, wr_gnt_i,
    input  pre_gnt_i, ref_gnt_i,
    output sched_ra_o, sched_ca_o,
    input  ref_req_i,
    output ref_gnt_o, bank_open_o, open_ra_o
  );

endinterface

// File: rtl/sal_tcntr.sv
// Saturating down-counter for one DDR timing constraint.
// is_zero_o high means the constraint is met.
module sal_tcntr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         is_zero_o
);

  logic [W-1:0] cnt;

  // Grant edge is the first elapsed cycle, so load t-1;
  // the next command is then legal exactly t cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= (val_i == '0) ? '0 : val_i - W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign is_zero_o = (cnt == '0);

endmodule

// File: rtl/sal_bk_ctrl_pp.sv
// Per-bank DDR2 controller with open/closed/adaptive
// page policy and refresh-by-precharge.
module sal_bk_ctrl_pp
  import sal_ddr_pkg::*;
#(
  parameter int RA_WIDTH   = DEF_RA_WIDTH,
  parameter int CA_WIDTH   = DEF_CA_WIDTH,
  parameter int TCNT_WIDTH = DEF_TCNT_WIDTH,
  parameter int IDLE_WIDTH = DEF_IDLE_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  sal_bk_ctrl_pp_if.slave bus
);

  bank_state_t          state, state_nxt;
  page_policy_t         policy;
  logic [RA_WIDTH-1:0]  open_ra;
  logic [IDLE_WIDTH-1:0] idle;

  logic act_req, rd_req, wr_req, pre_req, ref_req;
  logic act_fire, rd_fire, wr_fire, pre_fire, ref_fire;
  logic any_fire;
  logic rcd_ok, rp_ok, ras_ok, rfc_ok, rtp_ok, wtp_ok;
  logic pre_ok, hit, idle_done;

  assign policy = decode_policy(bus.page_policy_i);

  assign act_fire = act_req & bus.act_gnt_i;
  assign rd_fire  = rd_req  & bus.rd_gnt_i;
  assign wr_fire  = wr_req  & bus.wr_gnt_i;
  assign pre_fire = pre_req & bus.pre_gnt_i;
  assign ref_fire = ref_req & bus.ref_gnt_i;
  assign any_fire = act_fire | rd_fire | wr_fire
                  | pre_fire | ref_fire;

  sal_tcntr #(.W(TCNT_WIDTH)) u_rcd (
    .clk(clk), .rst_n(rst_n), .load_i(act_fire),
    .val_i(bus.t_rcd_i), .is_zero_o(rcd_ok)
  );
  sal_tcntr #(.W(TCNT_WIDTH)) u_ras (
    .clk(clk), .rst_n(rst_n), .load_i(act_fire),
    .val_i(bus.t_ras_i), .is_zero_o(ras_ok)
  );
  sal_tcntr #(.W(TCNT_WIDTH)) u_rp (
    .clk(clk), .rst_n(rst_n), .load_i(pre_fire),
    .val_i(bus.t_rp_i), .is_zero_o(rp_ok)
  );
  sal_tcntr #(.W(TCNT_WIDTH)) u_rfc (
    .clk(clk), .rst_n(rst_n), .load_i(ref_fire),
    .val_i(bus.t_rfc_i), .is_zero_o(rfc_ok)
  );
  sal_tcntr #(.W(TCNT_WIDTH)) u_rtp (
    .clk(clk), .rst_n(rst_n), .load_i(rd_fire),
    .val_i(bus.t_rtp_i), .is_zero_o(rtp_ok)
  );
  sal_tcntr #(.W(TCNT_WIDTH)) u_wtp (
    .clk(clk), .rst_n(rst_n), .load_i(wr_fire),
    .val_i(bus.t_wtp_i), .is_zero_o(wtp_ok)
  );

  assign pre_ok    = ras_ok & rtp_ok & wtp_ok;
  assign hit       = bus.req_valid_i
                   & (bus.req_ra_i == open_ra);
  assign idle_done = (idle >= bus.idle_limit_i);

  // Bank state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BK_CLOSED;
    else        state <= state_nxt;
  end

  // Latch the row on ACT grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        open_ra <= '0;
    else if (act_fire) open_ra <= bus.req_ra_i;
  end

  // Idle counter: counts request-free cycles, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle <= '0;
    end else if (bus.req_valid_i || any_fire) begin
      idle <= '0;
    end else if (idle != '1) begin
      idle <= idle + IDLE_WIDTH'(1);
    end
  end

  // Command selection and next state.
  always_comb begin
    state_nxt = state;
    act_req   = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    pre_req   = 1'b0;
    ref_req   = 1'b0;
    unique case (state)
      BK_CLOSED: begin
        if (rp_ok && rfc_ok) begin
          if (bus.ref_req_i)        ref_req = 1'b1;
          else if (bus.req_valid_i) act_req = 1'b1;
        end
        if (act_fire) state_nxt = BK_OPEN;
      end
      BK_OPEN: begin
        if (bus.ref_req_i) begin
          pre_req = pre_ok;
        end else if (bus.req_valid_i) begin
          if (hit) begin
            rd_req = rcd_ok & ~bus.req_wr_i;
            wr_req = rcd_ok &  bus.req_wr_i;
          end else begin
            pre_req = pre_ok;
          end
        end else begin
          case (policy)
            PP_CLOSED:   pre_req = pre_ok;
            PP_ADAPTIVE: pre_req = pre_ok & idle_done;
            default:     pre_req = 1'b0;
          endcase
        end
        if (pre_fire) state_nxt = BK_CLOSED;
      end
      default: state_nxt = BK_CLOSED;
    endcase
  end

  // Outputs forced low while reset is asserted.
  assign bus.act_req_o   = rst_n & act_req;
  assign bus.rd_req_o    = rst_n & rd_req;
  assign bus.wr_req_o    = rst_n & wr_req;
  assign bus.pre_req_o   = rst_n & pre_req;
  assign bus.ref_req_o   = rst_n & ref_req;
  assign bus.ref_gnt_o   = rst_n & ref_fire;
  assign bus.req_ready_o = rst_n & (rd_fire | wr_fire);
  assign bus.sched_ra_o  = rst_n ? bus.req_ra_i
                                 : RA_WIDTH'(0);
  assign bus.sched_ca_o  = rst_n ? bus.req_ca_i
                                 : CA_WIDTH'(0);
  assign bus.bank_open_o = (state == BK_OPEN);
  assign bus.open_ra_o   = open_ra;

endmodule
